temp_bcd_sseg_driver: RTL and testbench
=======================================

// Module: temp_bcd_sseg_driver
// PURPOSE
//   Display stage directly downstream of the temperature-conversion ROM.
//   - Takes the ROM's 8-bit converted temperature and the format select.
//   - Converts the value to 3-digit BCD with a sequential double-dabble FSM.
//   - Time-multiplexes hundreds/tens/ones plus a unit letter (C/F) onto a 4-digit seven-segment display.
// PARAMETERS
//   CNT_W  18  width of the scan refresh counter; digit select = cnt[CNT_W-1:CNT_W-2]
// PORTS
//   clk      in   1   system clock; all state on rising edge
//   reset_n  in   1   asynchronous, active-low reset
//   temp     in   8   converted temperature from ROM, unsigned 0..255
//   format   in   1   1: F->C, so display unit C; 0: C->F, so display unit F
//   bcd      out  12  {hundreds,tens,ones} of the last completed conversion
//   busy     out  1   high while a conversion is in progress
//   an       out  4   digit enables, active low; an[0] = unit, an[3] = hundreds
//   sseg     out  8   segments, active low, {dp,g,f,e,d,c,b,a}; dp always 1 (off)
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - an=4'b1111, sseg=8'hFF, bcd=12'h000, busy=0, FSM=IDLE, scan cnt=0.
//   - Internal flag `loaded`=0, forcing a conversion on the first IDLE cycle.
//   FSM IDLE -> SHIFT -> DONE -> IDLE:
//   - IDLE: go to SHIFT when (!loaded || temp!=last_temp || format!=last_fmt).
//     - On that edge: capture temp/format into working regs, sreg={12'h0,temp}, i=0, busy<=1.
//   - SHIFT: per cycle, add 3 to each BCD nibble >=5, then shift sreg left by 1, i++.
//     - After the 8th shift (i==7 at the edge), go to DONE.
//   - DONE: bcd<=sreg[19:8], shown_fmt<=captured format, last_temp/last_fmt<=captured,
//     loaded<=1, busy<=0, go to IDLE.
//   Latency and timing:
//   - Change detected at edge N; SHIFT covers edges N+1..N+8; bcd updates at N+9.
//   - busy is high for exactly 9 cycles.
//   - bcd and shown_fmt change atomically, only in DONE. No partial result is ever visible.
//   Input rules:
//   - temp/format changes during SHIFT are ignored.
//   - On return to IDLE, inputs are re-compared, so the final value always wins.
//   - This also absorbs the ROM's one-cycle output lag after a format toggle.
//   - The arithmetic needs no saturation: 255 -> 12'h255; ROM out-of-range 0 -> 12'h000.
//   Scan:
//   - cnt increments every cycle and wraps at 2^CNT_W.
//   - sel=cnt[CNT_W-1:CNT_W-2]: 0 -> unit (an=1110), 1 -> ones (1101), 2 -> tens (1011), 3 -> hundreds (0111).
//   - an and sseg are registered, so they lag sel by one cycle and change on the same edge (no ghosting skew).
//   Segment encoding:
//   - Digits 0-9: C0,F9,A4,B0,99,92,82,F8,80,90.
//   - Unit letters: C=8'hC6, F=8'h8E. Nibble >9 (unreachable) -> 8'hFF.
//   - Unit digit uses shown_fmt, not the live format input.
//   Reset mid-conversion: everything returns to reset values immediately; a fresh conversion starts after release.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//   - Hundreds digit drives sseg=8'hFF when its nibble is 0.
//   - Tens digit drives 8'hFF when hundreds and tens are both 0.
//   - Ones digit is never blanked. an still scans normally.
//   LEADING_ZERO_BLANK_EN undefined: all three digits always show their numeral (e.g. "007C").
// TESTING (bench uses CNT_W=4: each digit held 4 cycles)
//   1 Reset with temp=0 -> an=1111, sseg=FF, busy=0; after release busy high 9 cycles, bcd=000.
//   2 temp=212, format=0 -> bcd=12'h212 exactly 9 cycles after the detect edge;
//     unit slot shows 8'h8E; tens slot shows 8'hF9.
//   3 temp=100, format=1 -> bcd=12'h100, unit slot 8'hC6;
//     then toggle only format -> reconversion, bcd unchanged, unit 8'h8E.
//   4 temp=37, then temp=98 on the 3rd SHIFT cycle -> bcd=037 at DONE, then second pass,
//     bcd=098; no other values ever appear on bcd.
//   5 Scan: an sequence 1110,1101,1011,0111 repeats, 4 cycles each;
//     temp=7 with LEADING_ZERO_BLANK_EN gives hundreds/tens slots FF, ones F8;
//     without the macro they show C0,C0,F8.
//   6 Assert reset_n during SHIFT -> outputs reset same cycle (async);
//     after release, a full conversion of the current temp completes.

Source files
------------

// File: rtl/temp_bcd_sseg_driver.sv
// Converts the ROM's 8-bit temperature to 3-digit BCD (sequential double-dabble) and scans
// it with a C/F unit letter onto a 4-digit seven-segment display. Option: LEADING_ZERO_BLANK_EN.
module temp_bcd_sseg_driver #(
  parameter int unsigned CNT_W = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  temp,
  input  logic        format,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [3:0]  an,
  output logic [7:0]  sseg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             loaded_q;
  logic [7:0]       last_temp_q;
  logic             last_fmt_q;
  logic [7:0]       cap_temp_q;
  logic             cap_fmt_q;
  logic             shown_fmt_q;
  logic [19:0]      sreg_q;
  logic [19:0]      sreg_adj;
  logic [2:0]       idx_q;
  logic             start;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel;
  logic [3:0]       an_d;
  logic [7:0]       sseg_d;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // A never-loaded flag forces one conversion after reset even if temp is 0.
  assign start = !loaded_q || (temp != last_temp_q) || (format != last_fmt_q);

  always_comb begin
    sreg_adj = sreg_q;
    if (sreg_q[11:8] >= 4'd5) sreg_adj[11:8] = sreg_q[11:8] + 4'd3;
    if (sreg_q[15:12] >= 4'd5) sreg_adj[15:12] = sreg_q[15:12] + 4'd3;
    if (sreg_q[19:16] >= 4'd5) sreg_adj[19:16] = sreg_q[19:16] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (idx_q == 3'd7) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      loaded_q    <= 1'b0;
      last_temp_q <= 8'h00;
      last_fmt_q  <= 1'b0;
      cap_temp_q  <= 8'h00;
      cap_fmt_q   <= 1'b0;
      shown_fmt_q <= 1'b0;
      sreg_q      <= 20'h0;
      idx_q       <= 3'd0;
      busy        <= 1'b0;
      bcd         <= 12'h000;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cap_temp_q <= temp;
            cap_fmt_q  <= format;
            sreg_q     <= {12'h000, temp};
            idx_q      <= 3'd0;
            busy       <= 1'b1;
          end
        end
        ST_SHIFT: begin
          sreg_q <= sreg_adj << 1;
          idx_q  <= idx_q + 3'd1;
        end
        ST_DONE: begin
          // Result and unit letter publish together so the display never mixes passes.
          bcd         <= sreg_q[19:8];
          shown_fmt_q <= cap_fmt_q;
          last_temp_q <= cap_temp_q;
          last_fmt_q  <= cap_fmt_q;
          loaded_q    <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sel = cnt_q[CNT_W-1 -: 2];

  always_comb begin
    an_d   = 4'b1111;
    sseg_d = 8'hFF;
    case (sel)
      2'd0: begin
        an_d   = 4'b1110;
        sseg_d = shown_fmt_q ? 8'hC6 : 8'h8E;
      end
      2'd1: begin
        an_d   = 4'b1101;
        sseg_d = seg_enc(bcd[3:0]);
      end
      2'd2: begin
        an_d   = 4'b1011;
        sseg_d = seg_enc(bcd[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) sseg_d = 8'hFF;
`endif
      end
      default: begin
        an_d   = 4'b0111;
        sseg_d = seg_enc(bcd[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd[11:8] == 4'd0) sseg_d = 8'hFF;
`endif
      end
    endcase
  end

  // an and sseg share one register stage so digit enable and segments switch together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      an    <= 4'b1111;
      sseg  <= 8'hFF;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      an    <= an_d;
      sseg  <= sseg_d;
    end
  end

endmodule

// File: tb/tb_temp_bcd_sseg_driver.sv
// Scoreboard bench for temp_bcd_sseg_driver: stimulus queues expected conversions, a monitor
// checks each completed conversion, busy width, latency and every displayed digit slot.
module tb_temp_bcd_sseg_driver;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  temp = 8'd0;
  logic        format = 1'b0;
  logic [11:0] bcd;
  logic        busy;
  logic [3:0]  an;
  logic [7:0]  sseg;

  temp_bcd_sseg_driver #(.CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .temp    (temp),
    .format  (format),
    .bcd     (bcd),
    .busy    (busy),
    .an      (an),
    .sseg    (sseg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] val;
    logic        fmt;
    int          done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mlast_t = -1;
  int   mlast_f = -1;

  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Posedges since reset release; cnt before edge k equals k-1.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [11:0] ref_bcd(input int t);
    return {4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int t, input int f, input int lat);
    exp_t e;
    e.val  = ref_bcd(t);
    e.fmt  = f[0];
    e.done = cyc + lat;
    q.push_back(e);
    mlast_t = t;
    mlast_f = f;
  endtask

  task automatic wait_idle();
    bool_loop : for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (!busy && q.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL wait_idle: timeout busy=%0b pending=%0d", busy, q.size());
  endtask

  // Monitor state: model = last completed conversion; disp = model as of previous negedge.
  logic [11:0] model_bcd = 12'h000;
  logic        model_fmt = 1'b0;
  logic        model_ld = 1'b0;
  logic [11:0] disp_bcd = 12'h000;
  logic        disp_fmt = 1'b0;
  logic        disp_ld = 1'b0;
  logic        prev_busy = 1'b0;
  int          blen = 0;

  always @(negedge clk) begin
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [3:0] h, t, o;
    int sel;
    exp_t e;
    if (!reset_n) begin
      check("rst_an", int'(an), 'hF);
      check("rst_sseg", int'(sseg), 'hFF);
      check("rst_busy", int'(busy), 0);
      check("rst_bcd", int'(bcd), 0);
      prev_busy = 1'b0;
      blen = 0;
      model_bcd = 12'h000;
      model_fmt = 1'b0;
      model_ld = 1'b0;
    end else if (cyc > 0) begin
      sel = ((cyc - 1) % 16) / 4;
      exp_an = ~(4'b0001 << sel);
      h = disp_bcd[11:8];
      t = disp_bcd[7:4];
      o = disp_bcd[3:0];
      case (sel)
        0: exp_seg = disp_fmt ? 8'hC6 : 8'h8E;
        1: exp_seg = SEG[o];
        2: exp_seg = SEG[t];
        default: exp_seg = SEG[h];
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if (sel == 3 && h == 4'd0) exp_seg = 8'hFF;
      if (sel == 2 && h == 4'd0 && t == 4'd0) exp_seg = 8'hFF;
`endif
      check("scan_an", int'(an), int'(exp_an));
      if (sel != 0 || disp_ld) check("scan_sseg", int'(sseg), int'(exp_seg));
      if (busy) blen++;
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got bcd %0h with nothing pending", bcd);
        end else begin
          e = q.pop_front();
          check("done_bcd", int'(bcd), int'(e.val));
          check("done_cycle", cyc, e.done);
          check("busy_len", blen, 9);
          model_bcd = e.val;
          model_fmt = e.fmt;
          model_ld = 1'b1;
        end
        blen = 0;
      end else begin
        check("bcd_hold", int'(bcd), int'(model_bcd));
      end
      prev_busy = busy;
    end
    disp_bcd = model_bcd;
    disp_fmt = model_fmt;
    disp_ld = model_ld;
  end

  initial begin
    int rt, rf;
    // Reset with temp 0, then the forced first conversion.
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    push(0, 0, 10);
    wait_idle();

    temp = 8'd212; format = 1'b0; push(212, 0, 10);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;

    temp = 8'd100; format = 1'b1; push(100, 1, 10);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    format = 1'b0; push(100, 0, 10);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;

    // Mid-SHIFT change is ignored, then picked up on return to IDLE.
    temp = 8'd37; push(37, 0, 10);
    repeat (3) @(posedge clk);
    #1;
    temp = 8'd98; push(98, 0, 17);
    wait_idle();

    temp = 8'd7; push(7, 0, 10);
    wait_idle();
    repeat (40) @(posedge clk);
    #1;

    // Async reset during SHIFT, then a fresh conversion after release.
    temp = 8'd150; format = 1'b1; push(150, 1, 10);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_an", int'(an), 'hF);
    check("async_sseg", int'(sseg), 'hFF);
    check("async_busy", int'(busy), 0);
    check("async_bcd", int'(bcd), 0);
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    push(150, 1, 10);
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      rt = int'($urandom_range(0, 255));
      rf = int'($urandom_range(0, 1));
      if (k == 0) rt = 255;
      temp = rt[7:0];
      format = rf[0];
      if (rt != mlast_t || rf != mlast_f) push(rt, rf, 10);
      wait_idle();
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    wait_idle();
    repeat (20) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
